sram_burst_reader: RTL and testbench
====================================

Name: sram_burst_reader

Overview:
- Read-side initiator for the single-port synchronous SRAM wrapper (sram_top: cs/we/wem/addr/din/dout, 1-cycle read latency).
- Accepts a burst descriptor (start address, word count) and issues back-to-back SRAM reads with incrementing address.
- Absorbs the fixed read latency in a small credit-managed FIFO and presents words on a valid/ready stream with a last marker.
- Sits between the accelerator's feature/weight buffers and the compute datapath.

Parameters:
- DW, 64, SRAM data width / stream data width
- MW, 8, SRAM byte-write-mask width (DW/8)
- AW, 14, SRAM address width
- LW, 15, burst length width (max burst = 2^AW words)
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  descriptor accepted when valid&ready
- cmd_addr  in  AW  first word address
- cmd_len  in  LW  number of words; 0 = empty burst
- sram_cs  out  1  chip select to sram_top
- sram_we  out  1  tied 0 (read only)
- sram_wem  out  MW  tied 0
- sram_addr  out  AW  read address
- sram_din  out  DW  tied 0
- sram_dout  in  DW  read data, valid one cycle after cs sampled
- m_valid  out  1  stream data valid
- m_ready  in  1  stream consumer ready
- m_data  out  DW  stream data
- m_last  out  1  final word of burst, qualified by m_valid
- busy  out  1  burst in progress (state != IDLE)
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, rd_pend=0; outputs cmd_ready=1, sram_cs=0, sram_addr=0, m_valid=0, m_last=0, busy=0, done=0; m_data don't-care.
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On handshake, latch addr into cur_addr and len into rem_issue and rem_out.
  - len!=0: go to ISSUE.
  - len==0: stay in IDLE; done pulses the next cycle; no SRAM access; no stream beat.
- ISSUE: sram_cs = (rem_issue!=0) & (fifo_count + rd_pend < FIFO_DEPTH) (combinational from registers, no m_ready path); sram_addr = cur_addr.
  - On each cs cycle: cur_addr += 1 (wraps modulo 2^AW); rem_issue -= 1; rd_pend <= 1, otherwise rd_pend <= 0.
  - When the final cs is issued, go to DRAIN.
- Read return: when rd_pend=1, sram_dout is pushed into the FIFO at the end of that cycle.
  - Each entry carries a last tag, set when that word is the final word of the burst.
- Stream: m_valid = FIFO non-empty; m_data/m_last = FIFO head. A pop occurs on m_valid & m_ready.
  - m_data must hold stable while m_valid & !m_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- DRAIN: no cs. On the pop of the last-tagged word, go to IDLE and pulse done the next cycle. cmd_ready rises with IDLE.
- cmd_ready=0 in ISSUE and DRAIN; a new descriptor is never overlapped with a running burst.
- Latency: cmd handshake at edge E0.
  - First cs is high in the cycle after E0.
  - First m_valid is high two cycles after E0.
  - With m_ready held 1 and FIFO_DEPTH>=2, one word per cycle; N words complete in N+2 cycles after E0.
- Backpressure: with m_ready=0, at most FIFO_DEPTH reads are outstanding or buffered. cs stalls and resumes with no word lost or duplicated.
- Wrap: cmd_addr=2^AW-2, len=4 reads addresses 2^AW-2, 2^AW-1, 0, 1.
- The block never asserts sram_we; sram_wem and sram_din are constant 0.
- rst_n assertion mid-burst aborts immediately: FIFO cleared, no done. An in-flight SRAM read is discarded.

Decomposition:
- Package sram_rd_pkg:
  - state enum {IDLE, ISSUE, DRAIN}
  - localparam CNT_W = $clog2(FIFO_DEPTH)+1
  - stream entry struct {data[DW], last}
- One sub-module, sram_rd_fifo: synchronous FIFO of {last,data}, depth FIFO_DEPTH, async active-low reset; exports count, full, empty.
- Credit logic and FSM stay in the top.

Test Plan:
- Basic burst: memory model preloaded mem[a]=a; cmd addr=0x10, len=8, m_ready=1 -> data 0x10..0x17 on 8 consecutive cycles starting E0+2; m_last only on 0x17; done pulse one cycle after the last pop.
- Backpressure: len=16, m_ready toggles 1,0,0,1 repeating -> all 16 words in order, no duplicates; fifo_count+rd_pend never exceeds 4; m_data stable while stalled.
- Full stall: len=10, m_ready=0 for 20 cycles then 1 -> exactly 4 cs pulses during stall; remaining 6 issued after release; 10 words delivered.
- Wrap and single: addr=0x3FFE, len=4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001; then len=1 -> single beat with m_last=1.
- Empty burst: len=0 -> no sram_cs, no m_valid, done pulses once, cmd_ready stays 1.
- Reset mid-burst: rst_n low during word 3 of a len=8 burst -> all outputs at reset values immediately; a new len=2 burst afterward returns only its 2 words.

Source files
------------

// File: rtl/sram_rd_pkg.sv
// Shared types and sizing helpers for the SRAM burst reader.
package sram_rd_pkg;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DW_DEF         = 64;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned CNT_W          = cnt_w(FIFO_DEPTH_DEF);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    typedef struct packed {
        logic              last;
        logic [DW_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Synchronous FIFO for read-return words; head is presented combinationally from storage.
module sram_rd_fifo
    import sram_rd_pkg::*;
#(
    parameter int unsigned W     = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push_en, pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push & (~full | pop);
    assign pop_en  = pop & ~empty;
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed once counted.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read initiator: issues incrementing SRAM reads under FIFO credit and streams words out.
module sram_burst_reader
    import sram_rd_pkg::*;
#(
    parameter int unsigned DW         = 64,
    parameter int unsigned MW         = 8,
    parameter int unsigned AW         = 14,
    parameter int unsigned LW         = 15,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [MW-1:0] sram_wem,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = cnt_w(FIFO_DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [LW-1:0] rem_issue_q, rem_issue_d;
    logic          rd_pend_q, rd_last_q;
    logic          done_q, done_d;

    logic [DW:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [CW:0]   inflight;
    logic          credit_ok, issue, pop, final_issue;

    sram_rd_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_q),
        .push_data ({rd_last_q, sram_dout}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Credit counts buffered words plus the read in flight; no m_ready path into cs.
    assign inflight    = (CW + 1)'(fifo_count) + (CW + 1)'(rd_pend_q);
    assign credit_ok   = (inflight < (CW + 1)'(FIFO_DEPTH)) & ~fifo_full;
    assign issue       = (state_q == StIssue) & (rem_issue_q != '0) & credit_ok;
    assign final_issue = issue & (rem_issue_q == LW'(1));

    assign sram_cs   = issue;
    assign sram_addr = cur_addr_q;
    assign sram_we   = 1'b0;
    assign sram_wem  = '0;
    assign sram_din  = '0;

    assign m_valid   = ~fifo_empty;
    assign m_data    = fifo_head[DW-1:0];
    assign m_last    = ~fifo_empty & fifo_head[DW];
    assign pop       = m_valid & m_ready;

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_issue_d = rem_issue_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    rem_issue_d = cmd_len;
                    if (cmd_len != '0) state_d = StIssue;
                    else               done_d  = 1'b1;
                end
            end
            StIssue: begin
                if (issue) begin
                    cur_addr_d  = cur_addr_q + AW'(1);
                    rem_issue_d = rem_issue_q - LW'(1);
                    if (final_issue) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && fifo_head[DW]) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            rem_issue_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_issue_q <= rem_issue_d;
            rd_pend_q   <= issue;
            rd_last_q   <= final_issue;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Randomised scoreboard bench for sram_burst_reader with an SRAM behavioural model.
module tb_sram_burst_reader;
    import sram_rd_pkg::*;

    localparam int DW    = 64;
    localparam int MW    = 8;
    localparam int AW    = 14;
    localparam int LW    = 15;
    localparam int DEPTH = 4;

    logic          clk, rst_n;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          sram_cs, sram_we;
    logic [MW-1:0] sram_wem;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;
    logic          m_valid, m_ready, m_last, busy, done;
    logic [DW-1:0] m_data;

    sram_burst_reader #(
        .DW         (DW),
        .MW         (MW),
        .AW         (AW),
        .LW         (LW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_wem  (sram_wem),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {4{2'b00, a}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // SRAM model: one-cycle read latency.
    always @(posedge clk) if (sram_cs) sram_dout <= data_of(sram_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    entry_t        exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            exp_done = 0;
    int            done_cnt = 0;
    int            issued, popped;
    int            first_cs_cyc, first_valid_cyc, last_pop_cyc, done_cyc;
    logic          hold_valid = 1'b0;
    logic [DW-1:0] hold_data;

    // Monitor: everything it compares against comes from the queues filled at command time.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            check("ready_vs_busy", 64'(cmd_ready), 64'(!busy));
            if (hold_valid) check("stall_data_stable", m_data, hold_data);
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (sram_cs) begin
                if (first_cs_cyc < 0) first_cs_cyc = cyc;
                issued++;
                if (addr_q.size() == 0) check("unexpected_cs", 64'(1), 64'(0));
                else check("sram_addr", 64'(sram_addr), 64'(addr_q.pop_front()));
                check("write_ties", {sram_we, 7'd0, sram_wem, 48'(sram_din)}, 64'(0));
            end
            if (m_valid && m_ready) begin
                entry_t e;
                popped++;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) check("unexpected_beat", 64'(1), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.data);
                    check("m_last", 64'(m_last), 64'(e.last));
                end
            end
            if (sram_cs) check("outstanding_bound", 64'(issued - popped <= DEPTH), 64'(1));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            hold_valid = m_valid && !m_ready;
            hold_data  = m_data;
        end
    end

    // m_ready driver: 0 = always, 1 = 1,0,0,1 pattern, 2 = held low, 3 = random.
    int   rmode = 0;
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    initial begin
        int k = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0: m_ready = 1'b1;
                1: begin m_ready = pat[k % 4]; k++; end
                2: m_ready = 1'b0;
                default: m_ready = 1'($urandom % 2);
            endcase
        end
    end

    task automatic start_test();
        issued = 0; popped = 0;
        first_cs_cyc = -1; first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    endtask

    task automatic send(input logic [AW-1:0] addr, input int len, output int e0);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = LW'(len);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("cmd_accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        e0 = cyc;
        for (int i = 0; i < len; i++) begin
            entry_t e;
            e.data = data_of(addr + AW'(i));
            e.last = (i == len - 1);
            exp_q.push_back(e);
            addr_q.push_back(addr + AW'(i));
        end
        exp_done++;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || done_cnt < exp_done) && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check("burst_complete_in_time", 64'(n < budget), 64'(1));
        check("done_count", 64'(done_cnt), 64'(exp_done));
    endtask

    int e0, d0;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        start_test();
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_outputs", {sram_cs, m_valid, m_last, busy, done}, 64'(0));
        check("rst_sram_addr", 64'(sram_addr), 64'(0));
        rst_n = 1'b1;

        // Basic burst with exact latency.
        rmode = 0; start_test();
        send(14'h10, 8, e0);
        wait_idle(100);
        check("basic_first_cs", 64'(first_cs_cyc), 64'(e0));
        check("basic_first_valid", 64'(first_valid_cyc), 64'(e0 + 2));
        check("basic_last_pop", 64'(last_pop_cyc), 64'(e0 + 9));
        check("basic_done_cyc", 64'(done_cyc), 64'(e0 + 10));
        check("basic_words", 64'(popped), 64'(8));

        // Backpressure pattern.
        rmode = 1; start_test();
        send(14'(13'h1234), 16, e0);
        wait_idle(300);
        check("bp_words", 64'(popped), 64'(16));

        // Full stall then release.
        rmode = 2; start_test();
        send(14'h200, 10, e0);
        repeat (20) @(negedge clk);
        #1;
        check("stall_cs_count", 64'(issued), 64'(DEPTH));
        check("stall_no_pop", 64'(popped), 64'(0));
        rmode = 0;
        wait_idle(200);
        check("stall_words", 64'(popped), 64'(10));

        // Address wrap, then a single-word burst.
        start_test();
        send(14'h3FFE, 4, e0);
        wait_idle(100);
        check("wrap_words", 64'(popped), 64'(4));
        start_test();
        send(14'h0ABC, 1, e0);
        wait_idle(100);
        check("single_words", 64'(popped), 64'(1));

        // Empty burst.
        start_test(); d0 = done_cnt;
        send(14'h55, 0, e0);
        repeat (5) begin
            @(negedge clk); #1;
            check("empty_cmd_ready", 64'(cmd_ready), 64'(1));
        end
        check("empty_no_cs", 64'(issued), 64'(0));
        check("empty_no_valid", 64'(first_valid_cyc), 64'(-1));
        check("empty_done_once", 64'(done_cnt - d0), 64'(1));

        // Random bursts under random backpressure.
        rmode = 3;
        for (int t = 0; t < 6; t++) begin
            int len;
            len = 1 + int'($urandom_range(23));
            start_test();
            send(AW'($urandom), len, e0);
            wait_idle(400);
            check("rand_words", 64'(popped), 64'(len));
        end

        // Reset in the middle of a burst.
        rmode = 0; start_test();
        send(14'h0300, 8, e0);
        begin
            int n = 0;
            while (popped < 2 && n < 50) begin @(negedge clk); #1; n++; end
            check("mid_reset_reach_word3", 64'(popped), 64'(2));
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("mid_rst_outputs", {sram_cs, m_valid, m_last, busy, done}, 64'(0));
        check("mid_rst_sram_addr", 64'(sram_addr), 64'(0));
        exp_q.delete(); addr_q.delete();
        exp_done = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        start_test();
        send(14'h0400, 2, e0);
        wait_idle(100);
        repeat (3) @(negedge clk);
        #1;
        check("post_reset_words", 64'(popped), 64'(2));
        check("post_reset_done", 64'(done_cnt), 64'(exp_done));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
